// File: rtl/keypad_code_buffer.sv
// Keypad entry buffer: collects symbols, handles '*' (commit) and '#' (backspace).
// Optional inactivity timeout is built only when KEY_TIMEOUT_EN is defined.
module keypad_code_buffer #(
    parameter int MAX_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              key_code,
    input  logic                    key_valid,
    input  logic                    clear,
    output logic [4*MAX_DIGITS-1:0] code_out,
    output logic [3:0]              code_len,
    output logic                    code_valid,
    output logic [3:0]              entry_len,
    output logic                    overflow,
    output logic                    timeout
);

    localparam int BW = 4 * MAX_DIGITS;

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] COMMIT  = 2'd2;

    if (MAX_DIGITS < 1 || MAX_DIGITS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("keypad_code_buffer: parameter out of range");
    end

    logic [1:0]    state;
    logic [BW-1:0] buffer;
    logic          is_symbol;
    logic          is_enter;
    logic          expire;

    assign is_symbol = (key_code <= 4'hD);
    assign is_enter  = (key_code == 4'hE);

`ifdef KEY_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] idle_count;

    // A key on the expiry edge wins: it is processed and the count restarts.
    assign expire = (state == COLLECT) && !clear && !key_valid
                    && (idle_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_count <= '0;
            timeout    <= 1'b0;
        end else begin
            timeout <= expire;
            if (clear || key_valid || expire || state != COLLECT)
                idle_count <= '0;
            else
                idle_count <= idle_count + 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= EMPTY;
            buffer     <= '0;
            code_out   <= '0;
            code_len   <= '0;
            code_valid <= 1'b0;
            entry_len  <= '0;
            overflow   <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            if (state == COMMIT)
                state <= EMPTY;

            if (clear) begin
                buffer    <= '0;
                entry_len <= '0;
                overflow  <= 1'b0;
                state     <= EMPTY;
            end else if (key_valid) begin
                if (is_symbol) begin
                    if (entry_len < 4'(MAX_DIGITS)) begin
                        buffer    <= (buffer << 4) | BW'(key_code);
                        entry_len <= entry_len + 4'd1;
                        state     <= COLLECT;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (is_enter) begin
                    if (state == COLLECT) begin
                        code_out   <= buffer;
                        code_len   <= entry_len;
                        code_valid <= 1'b1;
                        buffer     <= '0;
                        entry_len  <= '0;
                        overflow   <= 1'b0;
                        state      <= COMMIT;
                    end
                end else if (state == COLLECT) begin
                    buffer    <= buffer >> 4;
                    entry_len <= entry_len - 4'd1;
                    if (entry_len == 4'd1)
                        state <= EMPTY;
                end
            end else if (expire) begin
                buffer    <= '0;
                entry_len <= '0;
                overflow  <= 1'b0;
                state     <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_keypad_code_buffer.sv
// Self-checking bench for keypad_code_buffer against a queue-based entry model.
module tb_keypad_code_buffer;

    localparam int MAXD = 4;
    localparam int TOUT = 10;
`ifdef KEY_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            clear;
    logic [15:0]     code_out;
    logic [3:0]      code_len;
    logic            code_valid;
    logic [3:0]      entry_len;
    logic            overflow;
    logic            timeout;

    keypad_code_buffer #(
        .MAX_DIGITS    (MAXD),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_code  (key_code),
        .key_valid (key_valid),
        .clear     (clear),
        .code_out  (code_out),
        .code_len  (code_len),
        .code_valid(code_valid),
        .entry_len (entry_len),
        .overflow  (overflow),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the entry is a queue of symbols, oldest first.
    int          q[$];
    bit          m_ovf   = 1'b0;
    logic [15:0] m_code  = '0;
    int          m_len   = 0;
    bit          m_valid = 1'b0;
    bit          m_to    = 1'b0;
    int          idle    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_code = '0; m_len = 0; m_valid = 1'b0; m_to = 1'b0; idle = 0;
    endtask

    task automatic model_edge(input logic kv, input logic [3:0] kc, input logic clr);
        logic [15:0] packed_code;
        m_valid = 1'b0;
        m_to    = 1'b0;
        if (clr) begin
            q.delete(); m_ovf = 1'b0; idle = 0;
        end else if (kv) begin
            idle = 0;
            if (kc <= 4'hD) begin
                if (q.size() < MAXD) q.push_back(int'(kc));
                else m_ovf = 1'b1;
            end else if (kc == 4'hE) begin
                if (q.size() > 0) begin
                    packed_code = '0;
                    for (int i = 0; i < q.size(); i++)
                        packed_code = (packed_code << 4) | 16'(q[i]);
                    m_code = packed_code; m_len = q.size(); m_valid = 1'b1;
                    q.delete(); m_ovf = 1'b0;
                end
            end else if (q.size() > 0) begin
                void'(q.pop_back());
            end
        end else if (TO_EN && q.size() > 0) begin
            idle++;
            if (idle == TOUT) begin
                q.delete(); m_ovf = 1'b0; idle = 0; m_to = 1'b1;
            end
        end
    endtask

    task automatic step(input logic kv, input logic [3:0] kc, input logic clr);
        @(negedge clk);
        key_valid = kv; key_code = kc; clear = clr;
        @(posedge clk);
        model_edge(kv, kc, clr);
        #1;
        check("entry_len",  32'(entry_len),  32'(q.size()));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("code_valid", 32'(code_valid), 32'(m_valid));
        check("code_out",   32'(code_out),   32'(m_code));
        check("code_len",   32'(code_len),   32'(m_len));
        check("timeout",    32'(timeout),    32'(m_to));
        key_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic press(input logic [3:0] kc);
        step(1'b1, kc, 1'b0);
    endtask

    task automatic idle_step();
        step(1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; key_code = '0; key_valid = 1'b0; clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_code_out",  32'(code_out),   32'h0);
        check("rst_entry_len", 32'(entry_len),  32'h0);
        check("rst_valid",     32'(code_valid), 32'h0);
        @(negedge clk); reset = 1'b1;

        // 4 6 9 3 *
        press(4'h4); press(4'h6); press(4'h9); press(4'h3); press(4'hE);
        check("plan1_code", 32'(code_out), 32'h4693);
        check("plan1_len",  32'(code_len), 32'h4);
        idle_step();
        check("plan1_after", 32'(entry_len), 32'h0);

        // A *, then * on empty
        press(4'hA); press(4'hE);
        check("plan2_code", 32'(code_out), 32'h000A);
        idle_step();
        press(4'hE);
        check("plan2_nopulse", 32'(code_valid), 32'h0);

        // overflow on fifth symbol
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        check("plan3_ovf", 32'(overflow), 32'h1);
        press(4'hE);
        check("plan3_code", 32'(code_out), 32'h1234);
        check("plan3_ovf_clr", 32'(overflow), 32'h0);

        // backspace, key accepted in the COMMIT cycle
        press(4'h7); press(4'h8); press(4'hF);
        check("plan4_len_bs", 32'(entry_len), 32'h1);
        press(4'h9); press(4'hE);
        check("plan4_code", 32'(code_out), 32'h0079);
        press(4'hF);
        press(4'h2); press(4'hE); press(4'h5); press(4'hE);
        check("commit_cycle_key", 32'(code_out), 32'h0005);

        // clear wins over a key in the same cycle
        press(4'h1); press(4'h2); press(4'h3);
        step(1'b1, 4'h5, 1'b1);
        check("plan5_clear", 32'(entry_len), 32'h0);
        check("plan5_keep_code", 32'(code_out), 32'h0005);

        // asynchronous reset mid-entry
        press(4'h2); press(4'h3);
        @(negedge clk); #2 reset = 1'b0; #1;
        check("async_rst_len",  32'(entry_len), 32'h0);
        check("async_rst_code", 32'(code_out),  32'h0);
        check("async_rst_clen", 32'(code_len),  32'h0);
        model_reset();
        @(negedge clk); reset = 1'b1;

        if (TO_EN) begin
            press(4'h3);
            repeat (TOUT - 1) idle_step();
            check("to_quiet", 32'(timeout), 32'h0);
            idle_step();
            check("to_pulse", 32'(timeout), 32'h1);
            check("to_len",   32'(entry_len), 32'h0);
            press(4'h3);
            repeat (TOUT - 1) idle_step();
            press(4'h4);
            check("to_saved", 32'(timeout), 32'h0);
            check("to_saved_len", 32'(entry_len), 32'h2);
            press(4'hE);
        end

        // randomized traffic with occasional idle bursts
        for (int n = 0; n < 400; n++) begin
            if (n % 60 == 59) begin
                for (int k = 0; k < 12; k++) idle_step();
            end else begin
                step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 24) == 0));
            end
        end
        for (int k = 0; k < 12; k++) idle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
